alu_muldiv: RTL and testbench

//  Parametrised multi-cycle integer execute unit for the EXU. Performs all single-cycle
//  ALU ops (incl. 32-bit W variants) plus iterative multiply and divide/remainder.

---
 rtl/alu_muldiv.sv | 238 +++++++++++++++++++++++
 tb/tb_alu_muldiv.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// alu_muldiv: multi-cycle integer execute unit (single-cycle ALU ops, shift-add multiply, restoring divide).
// Optional feature macro: ALU_FLUSH_EN adds a flush input that kills the in-flight operation.
module alu_muldiv #(
  parameter int XLEN = 64,
  parameter int OPW  = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] data,
`ifdef ALU_FLUSH_EN
  input  logic            flush,
`endif
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = SHW + 1;

  localparam logic [OPW-1:0] OP_ADD   = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB   = OPW'(1);
  localparam logic [OPW-1:0] OP_AND   = OPW'(2);
  localparam logic [OPW-1:0] OP_OR    = OPW'(3);
  localparam logic [OPW-1:0] OP_XOR   = OPW'(4);
  localparam logic [OPW-1:0] OP_SLT   = OPW'(5);
  localparam logic [OPW-1:0] OP_SLTU  = OPW'(6);
  localparam logic [OPW-1:0] OP_SLL   = OPW'(7);
  localparam logic [OPW-1:0] OP_SRL   = OPW'(8);
  localparam logic [OPW-1:0] OP_SRA   = OPW'(9);
  localparam logic [OPW-1:0] OP_ADDW  = OPW'(10);
  localparam logic [OPW-1:0] OP_SUBW  = OPW'(11);
  localparam logic [OPW-1:0] OP_SLLW  = OPW'(12);
  localparam logic [OPW-1:0] OP_SRLW  = OPW'(13);
  localparam logic [OPW-1:0] OP_SRAW  = OPW'(14);
  localparam logic [OPW-1:0] OP_MUL   = OPW'(15);
  localparam logic [OPW-1:0] OP_MULHU = OPW'(16);
  localparam logic [OPW-1:0] OP_DIV   = OPW'(17);
  localparam logic [OPW-1:0] OP_DIVU  = OPW'(18);
  localparam logic [OPW-1:0] OP_REM   = OPW'(19);
  localparam logic [OPW-1:0] OP_PASSB = OPW'(20);
  localparam logic [OPW-1:0] OP_REMU  = OPW'(21);

  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t            state_reg;
  logic              in_ready_reg, out_valid_reg, busy_reg;
  logic [XLEN-1:0]   data_reg;
  logic [OPW-1:0]    op_reg;
  logic [CW-1:0]     cnt_reg;
  logic [2*XLEN-1:0] prod_reg;
  logic [XLEN-1:0]   opnd_reg;
  logic              neg_q_reg, neg_r_reg;

  // Accept-time decode
  logic            is_mul, is_div, signed_div, div_zero, div_ovf, long_op;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] w_res, alu_res;

  assign is_mul     = (op == OP_MUL) || (op == OP_MULHU);
  assign is_div     = (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  assign signed_div = (op == OP_DIV) || (op == OP_REM);
  assign div_zero   = (b == '0);
  assign div_ovf    = signed_div && (a == MIN_VAL) && (b == '1);
  assign long_op    = is_mul || (is_div && !div_zero && !div_ovf);
  assign a_neg      = signed_div && a[XLEN-1];
  assign b_neg      = signed_div && b[XLEN-1];
  assign a_mag      = a_neg ? -a : a;
  assign b_mag      = b_neg ? -b : b;
  assign shamt      = b[SHW-1:0];

  generate
    if (XLEN == 64) begin : g_wops
      logic [31:0] w32;
      always_comb begin
        w32 = '0;
        case (op)
          OP_ADDW: w32 = a[31:0] + b[31:0];
          OP_SUBW: w32 = a[31:0] - b[31:0];
          OP_SLLW: w32 = a[31:0] << b[4:0];
          OP_SRLW: w32 = a[31:0] >> b[4:0];
          OP_SRAW: w32 = $signed(a[31:0]) >>> b[4:0];
          default: w32 = '0;
        endcase
      end
      assign w_res = {{32{w32[31]}}, w32};
    end else begin : g_no_wops
      // W ops are undefined codes on non-64-bit builds
      assign w_res = '0;
    end
  endgenerate

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:   alu_res = a + b;
      OP_SUB:   alu_res = a - b;
      OP_AND:   alu_res = a & b;
      OP_OR:    alu_res = a | b;
      OP_XOR:   alu_res = a ^ b;
      OP_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU:  alu_res = {{(XLEN-1){1'b0}}, a < b};
      OP_SLL:   alu_res = a << shamt;
      OP_SRL:   alu_res = a >> shamt;
      OP_SRA:   alu_res = $signed(a) >>> shamt;
      OP_ADDW, OP_SUBW, OP_SLLW, OP_SRLW, OP_SRAW: alu_res = w_res;
      OP_PASSB: alu_res = b;
      // Only reached for divide-by-zero or signed overflow
      OP_DIV, OP_DIVU: alu_res = div_ovf ? a : '1;
      OP_REM, OP_REMU: alu_res = div_ovf ? '0 : a;
      default:  alu_res = '0;
    endcase
  end

  // One radix-2 multiply step: conditionally add multiplicand to the high half, shift right
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_step;
  assign mul_sum  = {1'b0, prod_reg[2*XLEN-1:XLEN]} + (prod_reg[0] ? {1'b0, opnd_reg} : '0);
  assign mul_step = {mul_sum, prod_reg[XLEN-1:1]};

  // One restoring divide step on {remainder, dividend/quotient}
  logic [XLEN:0]     rem_sh;
  logic              div_fits;
  logic [2*XLEN-1:0] div_step;
  assign rem_sh   = {prod_reg[2*XLEN-1:XLEN], prod_reg[XLEN-1]};
  assign div_fits = (rem_sh >= {1'b0, opnd_reg});
  assign div_step = div_fits ? {rem_sh[XLEN-1:0] - opnd_reg, prod_reg[XLEN-2:0], 1'b1}
                             : {rem_sh[XLEN-1:0], prod_reg[XLEN-2:0], 1'b0};

  logic            op_reg_mul, op_reg_quo;
  logic [XLEN-1:0] quo, rem, fix_res;
  assign op_reg_mul = (op_reg == OP_MUL) || (op_reg == OP_MULHU);
  assign op_reg_quo = (op_reg == OP_DIV) || (op_reg == OP_DIVU);
  assign quo        = prod_reg[XLEN-1:0];
  assign rem        = prod_reg[2*XLEN-1:XLEN];
  assign fix_res    = op_reg_quo ? (neg_q_reg ? -quo : quo) : (neg_r_reg ? -rem : rem);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      data_reg      <= '0;
      op_reg        <= '0;
      cnt_reg       <= '0;
      prod_reg      <= '0;
      opnd_reg      <= '0;
      neg_q_reg     <= 1'b0;
      neg_r_reg     <= 1'b0;
    end
`ifdef ALU_FLUSH_EN
    else if (flush) begin
      state_reg     <= S_IDLE;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end
`endif
    else begin
      case (state_reg)
        S_IDLE: begin
          if (in_valid) begin
            op_reg       <= op;
            cnt_reg      <= '0;
            in_ready_reg <= 1'b0;
            if (long_op) begin
              state_reg <= S_BUSY;
              busy_reg  <= 1'b1;
              if (is_mul) begin
                prod_reg <= {{XLEN{1'b0}}, b};
                opnd_reg <= a;
              end else begin
                prod_reg  <= {{XLEN{1'b0}}, a_mag};
                opnd_reg  <= b_mag;
                neg_q_reg <= a_neg ^ b_neg;
                neg_r_reg <= a_neg;
              end
            end else begin
              state_reg     <= S_DONE;
              out_valid_reg <= 1'b1;
              data_reg      <= alu_res;
            end
          end
        end
        S_BUSY: begin
          if (op_reg_mul) begin
            prod_reg <= mul_step;
            cnt_reg  <= cnt_reg + 1'b1;
            if (cnt_reg == CW'(XLEN-1)) begin
              state_reg     <= S_DONE;
              busy_reg      <= 1'b0;
              out_valid_reg <= 1'b1;
              data_reg      <= (op_reg == OP_MUL) ? mul_step[XLEN-1:0] : mul_step[2*XLEN-1:XLEN];
            end
          end else if (cnt_reg != CW'(XLEN)) begin
            prod_reg <= div_step;
            cnt_reg  <= cnt_reg + 1'b1;
          end else begin
            // Sign-fixup cycle after all restoring steps
            state_reg     <= S_DONE;
            busy_reg      <= 1'b0;
            out_valid_reg <= 1'b1;
            data_reg      <= fix_res;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_reg     <= S_IDLE;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg     <= S_IDLE;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign busy      = busy_reg;
  assign data      = data_reg;

endmodule

// File: tb/tb_alu_muldiv.sv
// Randomised self-checking bench for alu_muldiv against a plain-arithmetic reference model.
// Flush scenarios are exercised when ALU_FLUSH_EN is defined.
module tb_alu_muldiv;

  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  op = '0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] data;
  logic        busy;
`ifdef ALU_FLUSH_EN
  logic        flush = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] last_data = '0;

  always #5 clk = ~clk;

  alu_muldiv #(.XLEN(64), .OPW(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .data(data),
`ifdef ALU_FLUSH_EN
    .flush(flush),
`endif
    .busy(busy));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_model(input logic [4:0] o, input logic [63:0] x, input logic [63:0] y);
    logic signed [63:0] sx, sy;
    logic [127:0]       p;
    logic [31:0]        w;
    logic signed [31:0] sw;
    sx = x;
    sy = y;
    p  = {64'd0, x} * {64'd0, y};
    case (o)
      5'd0:  return x + y;
      5'd1:  return x - y;
      5'd2:  return x & y;
      5'd3:  return x | y;
      5'd4:  return x ^ y;
      5'd5:  return (sx < sy) ? 64'd1 : 64'd0;
      5'd6:  return (x < y) ? 64'd1 : 64'd0;
      5'd7:  return x << y[5:0];
      5'd8:  return x >> y[5:0];
      5'd9:  return sx >>> y[5:0];
      5'd10: begin w = x[31:0] + y[31:0]; return {{32{w[31]}}, w}; end
      5'd11: begin w = x[31:0] - y[31:0]; return {{32{w[31]}}, w}; end
      5'd12: begin w = x[31:0] << y[4:0]; return {{32{w[31]}}, w}; end
      5'd13: begin w = x[31:0] >> y[4:0]; return {{32{w[31]}}, w}; end
      5'd14: begin sw = x[31:0]; sw = sw >>> y[4:0]; return {{32{sw[31]}}, sw}; end
      5'd15: return p[63:0];
      5'd16: return p[127:64];
      5'd17: begin
        if (y == 0) return ONES;
        if (x == MINV && y == ONES) return x;
        return sx / sy;
      end
      5'd18: return (y == 0) ? ONES : x / y;
      5'd19: begin
        if (y == 0) return x;
        if (x == MINV && y == ONES) return 64'd0;
        return sx % sy;
      end
      5'd20: return y;
      5'd21: return (y == 0) ? x : x % y;
      default: return 64'd0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [4:0] o, input logic [63:0] x, input logic [63:0] y);
    if (o == 5'd15 || o == 5'd16) return 65;
    if (o == 5'd18 || o == 5'd21) return (y == 0) ? 1 : 66;
    if (o == 5'd17 || o == 5'd19) return (y == 0 || (x == MINV && y == ONES)) ? 1 : 66;
    return 1;
  endfunction

  function automatic logic [63:0] rand_opnd();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return ONES;
      2: return MINV;
      3: return 64'($urandom_range(0, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic do_op(input logic [4:0] op_i, input logic [63:0] a_i, input logic [63:0] b_i, input int hold);
    logic [63:0] exp_d, held;
    int          exp_lat, lat;
    bit          busy_seen;
    exp_d   = ref_model(op_i, a_i, b_i);
    exp_lat = ref_lat(op_i, a_i, b_i);
    @(negedge clk);
    check("in_ready_idle", 64'(in_ready), 64'd1);
    in_valid = 1'b1; op = op_i; a = a_i; b = b_i;
    @(posedge clk); #1;
    in_valid = 1'b0; op = 5'($urandom); a = {$urandom, $urandom}; b = {$urandom, $urandom};
    lat = 1;
    busy_seen = 1'b0;
    while (!out_valid && lat < 200) begin
      busy_seen |= busy;
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(exp_lat));
    check("data", data, exp_d);
    check("busy_used", 64'(busy_seen), 64'(exp_lat > 1));
    check("busy_done", 64'(busy), 64'd0);
    check("in_ready_done", 64'(in_ready), 64'd0);
    held = data;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_data", data, held);
      check("hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_valid", 64'(out_valid), 64'd0);
    check("release_in_ready", 64'(in_ready), 64'd1);
    $display("[TB] op=%0d a=%h b=%h -> data=%h (exp %h) lat=%0d", op_i, a_i, b_i, held, exp_d, lat);
    last_data = held;
  endtask

  initial begin
    bit stale;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_data", data, 64'd0);
    @(negedge clk) rst_n = 1'b1;

    do_op(5'd0,  64'd3, 64'd4, 0);
    do_op(5'd15, ONES, 64'd2, 0);
    do_op(5'd16, ONES, 64'd2, 1);
    do_op(5'd17, -64'sd7, 64'd2, 0);
    do_op(5'd19, -64'sd7, 64'd2, 0);
    do_op(5'd18, 64'd100, 64'd7, 0);
    do_op(5'd18, 64'd5, 64'd0, 0);
    do_op(5'd17, MINV, ONES, 0);
    do_op(5'd19, MINV, ONES, 0);
    do_op(5'd21, 64'd9, 64'd0, 0);
    do_op(5'd14, 64'h8000_0000, 64'd4, 0);
    do_op(5'd31, ONES, ONES, 0);
    do_op(5'd1,  64'd50, 64'd8, 5);

    for (int i = 0; i < 50; i++)
      do_op(5'($urandom_range(0, 31)), rand_opnd(), rand_opnd(), $urandom_range(0, 2));

    // Asynchronous reset in the middle of a divide
    @(negedge clk);
    in_valid = 1'b1; op = 5'd17; a = 64'd1000; b = 64'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (19) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_data", data, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    stale = 1'b0;
    repeat (80) begin
      @(posedge clk); #1;
      if (out_valid) stale = 1'b1;
    end
    check("midrst_no_stale", 64'(stale), 64'd0);
    do_op(5'd18, 64'd1000, 64'd3, 0);

`ifdef ALU_FLUSH_EN
    // Flush mid-multiply: no result, data retains last value
    @(negedge clk);
    in_valid = 1'b1; op = 5'd15; a = 64'd12345; b = 64'd678;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (28) @(posedge clk);
    @(negedge clk) flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_data_kept", data, last_data);
    stale = 1'b0;
    repeat (80) begin
      @(posedge clk); #1;
      if (out_valid) stale = 1'b1;
    end
    check("flush_no_result", 64'(stale), 64'd0);

    // Flush and accept on the same edge: request dropped
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; op = 5'd0; a = 64'd1; b = 64'd2;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flushacc_in_ready", 64'(in_ready), 64'd1);
    check("flushacc_busy", 64'(busy), 64'd0);
    stale = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (out_valid) stale = 1'b1;
    end
    check("flushacc_dropped", 64'(stale), 64'd0);
    do_op(5'd15, 64'd12345, 64'd678, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
